// File: rtl/scc_wave_memory_if.sv
// Port bundle for scc_wave_memory: CPU access strobes, wave fetch port and status.
// The master side drives requests; the slave side (the wave memory) returns data.
interface scc_wave_memory_if;
    logic [2:0] sram_id;
    logic [4:0] sram_a;
    logic [7:0] sram_d;
    logic       sram_oe;
    logic       sram_we;
    logic [7:0] sram_q;
    logic       sram_q_en;
    logic       scci_enable;
    logic       wave_rd_req;
    logic [2:0] wave_id;
    logic [4:0] wave_a;
    logic [7:0] wave_q;
    logic       wave_q_en;
    logic       ready;
    logic       cpu_overflow;

    modport master (
        output sram_id, sram_a, sram_d, sram_oe, sram_we, scci_enable,
        output wave_rd_req, wave_id, wave_a,
        input  sram_q, sram_q_en, wave_q, wave_q_en, ready, cpu_overflow
    );

    modport slave (
        input  sram_id, sram_a, sram_d, sram_oe, sram_we, scci_enable,
        input  wave_rd_req, wave_id, wave_a,
        output sram_q, sram_q_en, wave_q, wave_q_en, ready, cpu_overflow
    );
endinterface

// File: rtl/scc_wave_memory.sv
// SCC wave-table RAM (5 x 32 bytes) with post-reset clear sequencer and a small CPU
// request FIFO that yields the single RAM port to tone-generator fetches.
module scc_wave_memory #(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                nreset,
    scc_wave_memory_if.slave    bus
);

    typedef enum logic {StInit, StRun} state_t;

    typedef struct packed {
        logic       we;
        logic [2:0] id;
        logic [4:0] a;
        logic [7:0] d;
    } cpu_req_t;

    localparam logic [7:0] ClrLast = 8'd159;

    logic [7:0] r_mem [160];
    logic [7:0] r_ram_q;
    cpu_req_t   r_fifo [FIFO_DEPTH];

    state_t     r_state;
    logic [7:0] r_clr_cnt;
    logic       r_ready;
    logic       r_overflow;
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       r_s1_wave;
    logic       r_s1_wave_zero;
    logic       r_s1_wave_ff;
    logic       r_s1_cpu;
    logic       r_s1_cpu_ff;
    logic [7:0] r_wave_q;
    logic       r_wave_q_en;
    logic [7:0] r_sram_q;
    logic       r_sram_q_en;

    cpu_req_t   w_head;
    cpu_req_t   w_new;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_accept;
    logic [2:0] w_wave_id;
    logic [2:0] w_head_id;
    logic       w_wave_ok;
    logic       w_head_rd_ok;
    logic       w_head_wr_ok;
    logic       w_ram_we;
    logic       w_ram_re;
    logic [7:0] w_ram_addr;
    logic [7:0] w_ram_wd;

    // In SCC mode channel E shares channel D's waveform.
    function automatic logic [2:0] f_alias_id(input logic [2:0] id, input logic scci);
        return (!scci && id == 3'd4) ? 3'd3 : id;
    endfunction

    always_comb begin
        w_head       = r_fifo[r_rd_ptr];
        w_new.we     = bus.sram_we;
        w_new.id     = bus.sram_id;
        w_new.a      = bus.sram_a;
        w_new.d      = bus.sram_d;
        w_push       = bus.sram_oe | bus.sram_we;
        w_full       = (r_count == 2'(FIFO_DEPTH));
        w_pop        = (r_state == StRun) && !bus.wave_rd_req && (r_count != 2'd0);
        w_accept     = w_push && (!w_full || w_pop);
        w_wave_id    = f_alias_id(bus.wave_id, bus.scci_enable);
        w_head_id    = f_alias_id(w_head.id, bus.scci_enable);
        w_wave_ok    = (bus.wave_id <= 3'd4);
        w_head_rd_ok = (w_head.id <= 3'd4);
        w_head_wr_ok = (w_head.id <= 3'd3) || (w_head.id == 3'd4 && bus.scci_enable);

        w_ram_we   = 1'b0;
        w_ram_re   = 1'b0;
        w_ram_addr = 8'h00;
        w_ram_wd   = 8'h00;
        if (r_state == StInit) begin
            w_ram_we   = 1'b1;
            w_ram_addr = r_clr_cnt;
        end else if (bus.wave_rd_req) begin
            w_ram_re   = w_wave_ok;
            w_ram_addr = {w_wave_id, bus.wave_a};
        end else if (w_pop) begin
            w_ram_addr = {w_head_id, w_head.a};
            w_ram_wd   = w_head.d;
            if (w_head.we) begin
                w_ram_we = w_head_wr_ok;
            end else begin
                w_ram_re = w_head_rd_ok;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_mem[w_ram_addr] <= w_ram_wd;
        end
        if (w_ram_re) begin
            r_ram_q <= r_mem[w_ram_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fifo[r_wr_ptr] <= w_new;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state        <= StInit;
            r_clr_cnt      <= 8'h00;
            r_ready        <= 1'b0;
            r_overflow     <= 1'b0;
            r_wr_ptr       <= 1'b0;
            r_rd_ptr       <= 1'b0;
            r_count        <= 2'd0;
            r_s1_wave      <= 1'b0;
            r_s1_wave_zero <= 1'b0;
            r_s1_wave_ff   <= 1'b0;
            r_s1_cpu       <= 1'b0;
            r_s1_cpu_ff    <= 1'b0;
            r_wave_q       <= 8'h00;
            r_wave_q_en    <= 1'b0;
            r_sram_q       <= 8'h00;
            r_sram_q_en    <= 1'b0;
        end else begin
            if (r_state == StInit) begin
                r_clr_cnt <= r_clr_cnt + 8'd1;
                if (r_clr_cnt == ClrLast) begin
                    r_state <= StRun;
                    r_ready <= 1'b1;
                end
            end

            if (w_accept) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_accept} - {1'b0, w_pop};
            if (w_push && !w_accept) begin
                r_overflow <= 1'b1;
            end

            // Stage 1 tracks what the RAM port did; stage 2 forms the output strobes.
            r_s1_wave      <= bus.wave_rd_req;
            r_s1_wave_zero <= (r_state == StInit);
            r_s1_wave_ff   <= !w_wave_ok;
            r_s1_cpu       <= w_pop && !w_head.we;
            r_s1_cpu_ff    <= !w_head_rd_ok;

            r_wave_q_en <= r_s1_wave;
            if (r_s1_wave) begin
                r_wave_q <= r_s1_wave_zero ? 8'h00 : (r_s1_wave_ff ? 8'hFF : r_ram_q);
            end
            r_sram_q_en <= r_s1_cpu;
            if (r_s1_cpu) begin
                r_sram_q <= r_s1_cpu_ff ? 8'hFF : r_ram_q;
            end
        end
    end

    assign bus.sram_q       = r_sram_q;
    assign bus.sram_q_en    = r_sram_q_en;
    assign bus.wave_q       = r_wave_q;
    assign bus.wave_q_en    = r_wave_q_en;
    assign bus.ready        = r_ready;
    assign bus.cpu_overflow = r_overflow;

endmodule

// File: tb/tb_scc_wave_memory.sv
// Bench for scc_wave_memory: a queue/array model checked every cycle, plus vector
// table and hand-written sequences for reset, contention, overflow and aliasing.
module tb_scc_wave_memory;

    logic clk = 1'b0;
    logic nreset;

    scc_wave_memory_if bus ();

    scc_wave_memory #(.FIFO_DEPTH(2)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct { bit we; bit [2:0] id; bit [4:0] a; bit [7:0] d; } req_t;
    typedef struct { int due; bit [7:0] d; } exp_t;
    typedef struct {
        bit       scci;
        bit [2:0] wid;
        bit [4:0] wa;
        bit [7:0] wd;
        bit [2:0] rid;
        bit [4:0] ra;
        bit [7:0] exp_q;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state.
    bit [7:0] m_mem [160];
    req_t     m_q [$];
    exp_t     m_exp_w [$];
    exp_t     m_exp_s [$];
    bit       m_init;
    bit       m_ready;
    bit       m_ovf;
    int       m_clr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int m_addr(input bit [2:0] id, input bit [4:0] a);
        int eff;
        eff = (id == 3'd4 && !bus.scci_enable) ? 3 : int'(id);
        return eff * 32 + int'(a);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_exp_w.delete();
        m_exp_s.delete();
        m_init  = 1'b1;
        m_ready = 1'b0;
        m_ovf   = 1'b0;
        m_clr   = 0;
    endtask

    // Applies this cycle's inputs to the model; results fall due two cycles later.
    task automatic model_cycle();
        exp_t e;
        req_t r;
        e.due = cyc + 2;
        if (m_init) begin
            if (bus.wave_rd_req) begin
                e.d = 8'h00;
                m_exp_w.push_back(e);
            end
            m_mem[m_clr] = 8'h00;
            if (m_clr == 159) begin
                m_init  = 1'b0;
                m_ready = 1'b1;
            end
            m_clr++;
        end else if (bus.wave_rd_req) begin
            e.d = (bus.wave_id > 3'd4) ? 8'hFF : m_mem[m_addr(bus.wave_id, bus.wave_a)];
            m_exp_w.push_back(e);
        end else if (m_q.size() > 0) begin
            r = m_q.pop_front();
            if (r.we) begin
                if (r.id < 3'd4 || (r.id == 3'd4 && bus.scci_enable)) begin
                    m_mem[m_addr(r.id, r.a)] = r.d;
                end
            end else begin
                e.d = (r.id > 3'd4) ? 8'hFF : m_mem[m_addr(r.id, r.a)];
                m_exp_s.push_back(e);
            end
        end
        if (bus.sram_oe || bus.sram_we) begin
            if (m_q.size() < 2) begin
                r.we = bus.sram_we;
                r.id = bus.sram_id;
                r.a  = bus.sram_a;
                r.d  = bus.sram_d;
                m_q.push_back(r);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        bit   ew;
        bit   es;
        exp_t e;
        ew = (m_exp_w.size() > 0) && (m_exp_w[0].due == cyc);
        es = (m_exp_s.size() > 0) && (m_exp_s[0].due == cyc);
        chk("wave_q_en", 32'(bus.wave_q_en), 32'(ew));
        if (ew) begin
            e = m_exp_w.pop_front();
            chk("wave_q", 32'(bus.wave_q), 32'(e.d));
        end
        chk("sram_q_en", 32'(bus.sram_q_en), 32'(es));
        if (es) begin
            e = m_exp_s.pop_front();
            chk("sram_q", 32'(bus.sram_q), 32'(e.d));
        end
        chk("ready", 32'(bus.ready), 32'(m_ready));
        chk("cpu_overflow", 32'(bus.cpu_overflow), 32'(m_ovf));
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic clear_inputs();
        bus.sram_oe     = 1'b0;
        bus.sram_we     = 1'b0;
        bus.sram_id     = 3'd0;
        bus.sram_a      = 5'd0;
        bus.sram_d      = 8'h00;
        bus.wave_rd_req = 1'b0;
        bus.wave_id     = 3'd0;
        bus.wave_a      = 5'd0;
    endtask

    // Called just after a clock edge; leaves reset released before the next edge.
    task automatic do_reset();
        clear_inputs();
        nreset = 1'b0;
        #1;
        model_reset();
        chk("rst_sram_q", 32'(bus.sram_q), 32'h0);
        chk("rst_sram_q_en", 32'(bus.sram_q_en), 32'h0);
        chk("rst_wave_q", 32'(bus.wave_q), 32'h0);
        chk("rst_wave_q_en", 32'(bus.wave_q_en), 32'h0);
        chk("rst_ready", 32'(bus.ready), 32'h0);
        chk("rst_cpu_overflow", 32'(bus.cpu_overflow), 32'h0);
        #1;
        nreset = 1'b1;
    endtask

    // Edges from deassert until ready is seen; 160 edges puts the rise in cycle 161.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!bus.ready && n < 400) begin
            step();
            n++;
        end
        chk(name, 32'(n), 32'd160);
    endtask

    task automatic cpu_write(input bit [2:0] id, input bit [4:0] a, input bit [7:0] d);
        bus.sram_id = id;
        bus.sram_a  = a;
        bus.sram_d  = d;
        bus.sram_we = 1'b1;
        step();
        bus.sram_we = 1'b0;
    endtask

    task automatic cpu_read(input bit [2:0] id, input bit [4:0] a,
                            output bit [7:0] q, output int lat);
        bus.sram_id = id;
        bus.sram_a  = a;
        bus.sram_oe = 1'b1;
        step();
        bus.sram_oe = 1'b0;
        lat = 1;
        while (!bus.sram_q_en && lat < 30) begin
            step();
            lat++;
        end
        q = bus.sram_q;
        if (!bus.sram_q_en) lat = -1;
    endtask

    task automatic wave_read(input bit [2:0] id, input bit [4:0] a,
                             output bit [7:0] q, output int lat);
        bus.wave_id     = id;
        bus.wave_a      = a;
        bus.wave_rd_req = 1'b1;
        step();
        bus.wave_rd_req = 1'b0;
        lat = 1;
        while (!bus.wave_q_en && lat < 30) begin
            step();
            lat++;
        end
        q = bus.wave_q;
        if (!bus.wave_q_en) lat = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t     vecs [8];
        bit [7:0] q;
        int       lat;
        int       qcyc;
        int       wcnt;
        int       wfirst;
        int       wlast;
        int       r;

        vecs[0] = '{1'b1, 3'd2, 5'd7,  8'h5A, 3'd2, 5'd7,  8'h5A};
        vecs[1] = '{1'b0, 3'd3, 5'd0,  8'h80, 3'd4, 5'd0,  8'h80};
        vecs[2] = '{1'b0, 3'd4, 5'd0,  8'h33, 3'd3, 5'd0,  8'h80};
        vecs[3] = '{1'b1, 3'd4, 5'd0,  8'h44, 3'd4, 5'd0,  8'h44};
        vecs[4] = '{1'b1, 3'd6, 5'd0,  8'h99, 3'd3, 5'd0,  8'h80};
        vecs[5] = '{1'b1, 3'd0, 5'd0,  8'h01, 3'd0, 5'd0,  8'h01};
        vecs[6] = '{1'b1, 3'd4, 5'd31, 8'hFE, 3'd4, 5'd31, 8'hFE};
        vecs[7] = '{1'b1, 3'd6, 5'd3,  8'h77, 3'd6, 5'd3,  8'hFF};

        nreset = 1'b1;
        bus.scci_enable = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        do_reset();
        wait_ready("ready_after_reset");

        // Every location reads back as cleared.
        bus.wave_rd_req = 1'b1;
        for (int id = 0; id < 5; id++) begin
            for (int a = 0; a < 32; a++) begin
                bus.wave_id = 3'(id);
                bus.wave_a  = 5'(a);
                step();
            end
        end
        bus.wave_rd_req = 1'b0;
        repeat (3) step();

        // Three writes while fetches hold the port: the third has nowhere to go.
        bus.wave_rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_write(3'd1, 5'(i + 1), 8'(8'h11 * (i + 1)));
            if (i == 1) chk("ovf_after_two", 32'(bus.cpu_overflow), 32'h0);
        end
        chk("ovf_after_three", 32'(bus.cpu_overflow), 32'h1);
        bus.wave_rd_req = 1'b0;
        repeat (3) step();
        cpu_read(3'd1, 5'd1, q, lat);
        chk("ovf_first_kept", 32'(q), 32'h11);
        cpu_read(3'd1, 5'd2, q, lat);
        chk("ovf_second_kept", 32'(q), 32'h22);
        cpu_read(3'd1, 5'd3, q, lat);
        chk("ovf_third_dropped", 32'(q), 32'h00);

        foreach (vecs[i]) begin
            bus.scci_enable = vecs[i].scci;
            cpu_write(vecs[i].wid, vecs[i].wa, vecs[i].wd);
            cpu_read(vecs[i].rid, vecs[i].ra, q, lat);
            chk($sformatf("vec%0d_cpu_q", i), 32'(q), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d_cpu_lat", i), 32'(lat), 32'd3);
            wave_read(vecs[i].rid, vecs[i].ra, q, lat);
            chk($sformatf("vec%0d_wave_q", i), 32'(q), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d_wave_lat", i), 32'(lat), 32'd2);
            repeat (2) step();
        end

        // CPU read in N with fetches held N..N+4: the read waits four cycles.
        bus.scci_enable = 1'b1;
        bus.sram_id = 3'd2;
        bus.sram_a  = 5'd7;
        bus.sram_oe = 1'b1;
        bus.wave_rd_req = 1'b1;
        bus.wave_id = 3'd0;
        bus.wave_a  = 5'd5;
        qcyc = -1;
        wcnt = 0;
        wfirst = -1;
        wlast = -1;
        q = 8'h00;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) bus.sram_oe = 1'b0;
            if (k == 5) bus.wave_rd_req = 1'b0;
            if (bus.sram_q_en && qcyc < 0) begin
                qcyc = k;
                q = bus.sram_q;
            end
            if (bus.wave_q_en) begin
                wcnt++;
                if (wfirst < 0) wfirst = k;
                wlast = k;
            end
        end
        chk("cont_sram_q_en_cycle", 32'(qcyc), 32'd7);
        chk("cont_sram_q", 32'(q), 32'h5A);
        chk("cont_wave_count", 32'(wcnt), 32'd5);
        chk("cont_wave_first", 32'(wfirst), 32'd2);
        chk("cont_wave_last", 32'(wlast), 32'd6);

        // Random traffic; the mode only changes once everything has drained.
        for (int blk = 0; blk < 4; blk++) begin
            bus.scci_enable = 1'($urandom_range(0, 1));
            for (int c = 0; c < 600; c++) begin
                bus.wave_rd_req = ($urandom_range(0, 99) < 45);
                bus.wave_id = 3'($urandom_range(0, 4));
                bus.wave_a  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3))
                                                           : 5'($urandom_range(0, 31));
                r = int'($urandom_range(0, 99));
                bus.sram_oe = (r < 20);
                bus.sram_we = (r >= 15) && (r < 35);
                bus.sram_id = 3'($urandom_range(0, 7));
                bus.sram_a  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3))
                                                           : 5'($urandom_range(0, 31));
                bus.sram_d  = 8'($urandom_range(0, 255));
                step();
            end
            clear_inputs();
            repeat (10) step();
        end

        // Reset again during the clear; it restarts from address 0.
        do_reset();
        repeat (49) step();
        do_reset();
        wait_ready("ready_after_mid_init_reset");
        cpu_read(3'd6, 5'd3, q, lat);
        chk("invalid_id_q", 32'(q), 32'hFF);
        chk("invalid_id_lat", 32'(lat), 32'd3);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
